// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing multi-cycle MIPS instructions and driving datapath controls
module multicycle_control #(
    parameter int OP_W          = 6,
    parameter int ALUOP_W       = 2,
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op_code,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);

    state_t          r_state;
    logic [OP_W-1:0] r_op;
    logic            w_rdy;
    logic            w_legal;

    assign w_rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_legal = (op_code == OP_R) || (op_code == OP_LW) || (op_code == OP_SW) ||
                     (op_code == OP_BEQ) || (op_code == OP_BNE) || (op_code == OP_J) ||
                     (op_code == OP_ADDI) || (op_code == OP_ANDI);
    assign state_o = rst ? '0 : STATE_W'(r_state);

    // State register and opcode capture; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= w_rdy ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    r_op <= op_code;
                    if (op_code == OP_R)                             r_state <= S_EXEC;
                    else if (op_code == OP_LW || op_code == OP_SW)   r_state <= S_MEMADR;
                    else if (op_code == OP_BEQ)                      r_state <= S_BEQ;
                    else if (op_code == OP_BNE)                      r_state <= S_BNE;
                    else if (op_code == OP_J)                        r_state <= S_JUMP;
                    else if (op_code == OP_ADDI || op_code == OP_ANDI) r_state <= S_IEXEC;
                    else                                             r_state <= S_FETCH;
                end
                S_MEMADR: r_state <= (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= w_rdy ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= w_rdy ? S_FETCH : S_MEMWR;
                S_EXEC:   r_state <= S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Control decode from current state; FETCH and the memory states also look at mem_ready
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        IRWrite       = 1'b0;
        PCSource      = 2'b00;
        ALUOp         = '0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = w_rdy;
                    PCWrite = w_rdy;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !w_legal;
                    instr_done = !w_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = w_rdy;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_W'(2'b10);
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ, S_BNE: begin
                    ALUSrcA       = 1'b1;
                    ALUOp         = ALUOP_W'(2'b01);
                    PCWriteCond   = (r_state == S_BEQ);
                    PCWriteCondNe = (r_state == S_BNE);
                    PCSource      = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = (r_op == OP_ANDI) ? ALUOP_W'(2'b11) : ALUOP_W'(2'b00);
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle check of state and every control output
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_code = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
    logic [3:0] state_o;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .RegDst(RegDst), .instr_done(instr_done),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    logic [18:0] w_ctl;
    assign w_ctl = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
                    instr_done, illegal_op};

    function automatic logic [18:0] v(input logic pcw, pcwc, pcwne, iord, mr, mw, m2r, irw,
                                      input logic [1:0] pcs, aop, input logic asa,
                                      input logic [1:0] asb, input logic rw, rd, done, ill);
        return {pcw, pcwc, pcwne, iord, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, done, ill};
    endfunction

    localparam logic [18:0] ZERO    = 19'd0;
    localparam logic [18:0] FETCH1  = v(1,0,0,0,1,0,0,1,2'b00,2'b00,0,2'b01,0,0,0,0);
    localparam logic [18:0] FETCH0  = v(0,0,0,0,1,0,0,0,2'b00,2'b00,0,2'b01,0,0,0,0);
    localparam logic [18:0] DEC     = v(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,0);
    localparam logic [18:0] DEC_ILL = v(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,1,1);
    localparam logic [18:0] MADR    = v(0,0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0);
    localparam logic [18:0] MRD     = v(0,0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,0);
    localparam logic [18:0] MWB     = v(0,0,0,0,0,0,1,0,2'b00,2'b00,0,2'b00,1,0,1,0);
    localparam logic [18:0] MWR0    = v(0,0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,0,0);
    localparam logic [18:0] MWR1    = v(0,0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,1,0);
    localparam logic [18:0] EXEC    = v(0,0,0,0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0,0,0);
    localparam logic [18:0] RWB     = v(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1,1,0);
    localparam logic [18:0] BEQ     = v(0,1,0,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0,1,0);
    localparam logic [18:0] BNE     = v(0,0,1,0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0,1,0);
    localparam logic [18:0] JMP     = v(1,0,0,0,0,0,0,0,2'b10,2'b00,0,2'b00,0,0,1,0);
    localparam logic [18:0] IEX_ADD = v(0,0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0);
    localparam logic [18:0] IEX_AND = v(0,0,0,0,0,0,0,0,2'b00,2'b11,1,2'b10,0,0,0,0);
    localparam logic [18:0] IWB     = v(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0,1,0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [3:0] es, input logic [18:0] ec);
        op_code   = op;
        mem_ready = rdy;
        #1;
        check({tag, ".state"}, 32'(state_o), 32'(es));
        check({tag, ".ctl"}, 32'(w_ctl), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst0.state", 32'(state_o), 32'd0);
        check("rst0.ctl", 32'(w_ctl), 32'(ZERO));
        @(posedge clk); #1;
        check("rst1.state", 32'(state_o), 32'd0);
        check("rst1.ctl", 32'(w_ctl), 32'(ZERO));
        @(posedge clk); #1;
        check("rst2.ctl", 32'(w_ctl), 32'(ZERO));
        rst = 1'b0;
        // lw, no waits: 5 cycles
        cyc("lw.f",   6'b100011, 1, 4'd0, FETCH1);
        cyc("lw.d",   6'b100011, 1, 4'd1, DEC);
        cyc("lw.a",   6'b100011, 1, 4'd2, MADR);
        cyc("lw.r",   6'b100011, 1, 4'd3, MRD);
        cyc("lw.wb",  6'b100011, 1, 4'd4, MWB);
        // sw with three wait cycles in MEMWR
        cyc("sw.f",   6'b101011, 1, 4'd0, FETCH1);
        cyc("sw.d",   6'b101011, 1, 4'd1, DEC);
        cyc("sw.a",   6'b101011, 1, 4'd2, MADR);
        cyc("sw.w0",  6'b101011, 0, 4'd5, MWR0);
        cyc("sw.w1",  6'b101011, 0, 4'd5, MWR0);
        cyc("sw.w2",  6'b101011, 0, 4'd5, MWR0);
        cyc("sw.w3",  6'b101011, 1, 4'd5, MWR1);
        cyc("bne.f",  6'b000101, 1, 4'd0, FETCH1);
        cyc("bne.d",  6'b000101, 1, 4'd1, DEC);
        cyc("bne.b",  6'b000101, 1, 4'd9, BNE);
        cyc("beq.f",  6'b000100, 1, 4'd0, FETCH1);
        cyc("beq.d",  6'b000100, 1, 4'd1, DEC);
        cyc("beq.b",  6'b000100, 1, 4'd8, BEQ);
        // andi: op_code changes after DECODE to prove it is held internally
        cyc("andi.f", 6'b001100, 1, 4'd0, FETCH1);
        cyc("andi.d", 6'b001100, 1, 4'd1, DEC);
        cyc("andi.x", 6'b001000, 1, 4'd11, IEX_AND);
        cyc("andi.w", 6'b001000, 1, 4'd12, IWB);
        cyc("addi.f", 6'b001000, 1, 4'd0, FETCH1);
        cyc("addi.d", 6'b001000, 1, 4'd1, DEC);
        cyc("addi.x", 6'b001100, 1, 4'd11, IEX_ADD);
        cyc("addi.w", 6'b001000, 1, 4'd12, IWB);
        cyc("r.f",    6'b000000, 1, 4'd0, FETCH1);
        cyc("r.d",    6'b000000, 1, 4'd1, DEC);
        cyc("r.x",    6'b000000, 1, 4'd6, EXEC);
        cyc("r.w",    6'b000000, 1, 4'd7, RWB);
        cyc("j.f",    6'b000010, 1, 4'd0, FETCH1);
        cyc("j.d",    6'b000010, 1, 4'd1, DEC);
        cyc("j.j",    6'b000010, 1, 4'd10, JMP);
        // illegal opcode, then a FETCH that waits on memory
        cyc("ill.f",  6'b111111, 1, 4'd0, FETCH1);
        cyc("ill.d",  6'b111111, 1, 4'd1, DEC_ILL);
        cyc("fw.f0",  6'b100011, 0, 4'd0, FETCH0);
        cyc("fw.f1",  6'b100011, 1, 4'd0, FETCH1);
        // lw (from the fetch above) with a MEMRD wait, then reset while in MEMRD
        cyc("lr.d",   6'b100011, 1, 4'd1, DEC);
        cyc("lr.a",   6'b100011, 1, 4'd2, MADR);
        cyc("lr.r0",  6'b100011, 0, 4'd3, MRD);
        cyc("lr.r1",  6'b100011, 0, 4'd3, MRD);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("mrst.state", 32'(state_o), 32'd0);
        check("mrst.ctl", 32'(w_ctl), 32'(ZERO));
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("post.f", 6'b000000, 1, 4'd0, FETCH1);
        cyc("post.d", 6'b000000, 1, 4'd1, DEC);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM controller for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives all datapath mux selects and write enables. Supports a memory-ready handshake, a distinct bne, and illegal-opcode detection.
- Sits between the instruction register's opcode field and the shared datapath (PC, memory, register file, ALU).

Parameters:
- OP_W, 6, opcode field width.
- ALUOP_W, 2, ALUOp width to the ALU-control block.
- MEM_HANDSHAKE, 1, 1 = memory states wait on mem_ready; 0 = mem_ready is ignored and treated as 1.
- STATE_W, 4, width of the state_o debug output.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_code  in  OP_W  opcode from the instruction register. Sampled in DECODE only.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- PCWriteCondNe  out  1  PC load if ALU not zero (bne).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemtoReg  out  1  register write data select: 1 = MDR.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  out  ALUOP_W  00 = add, 01 = sub, 10 = funct, 11 = and.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  destination register select: 1 = rd.
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state_o  out  STATE_W  current state encoding, for debug.

Behaviour:
- Reset: the state register loads FETCH (encoding 0) on the first clk edge with rst=1. While rst=1, every output is forced to 0, including state_o. Reset mid-instruction abandons that instruction without completing any write.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, BNE=9, JUMP=10, IEXEC=11, IWB=12.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready (Mealy).
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by op_code: 000000 -> EXEC; 100011 (lw) or 101011 (sw) -> MEMADR; 000100 -> BEQ; 000101 -> BNE; 000010 -> JUMP; 001000 (addi) or 001100 (andi) -> IEXEC.
  - Any other opcode: illegal_op=1 this cycle, instr_done=1, next state FETCH, no write performed.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw. The opcode is held from DECODE in an internal register.
- MEMRD:
  - MemRead=1, IorD=1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next state FETCH.
- MEMWR:
  - MemWrite=1, IorD=1.
  - Stay in MEMWR while mem_ready=0. On mem_ready=1: instr_done=1, next state FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next state FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state FETCH.
- BNE: same as BEQ, but PCWriteCondNe=1 and PCWriteCond=0.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next state FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi. Next state IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next state FETCH.
- Defaults: any output not listed for a state is 0 in that state.
- Safety: unused state encodings go to FETCH on the next clk with all outputs 0.
- Cycle counts with mem_ready held at 1:
  - lw 5.
  - sw, R-type, addi and andi 4.
  - beq, bne and j 3.
  - Each wait cycle at mem_ready=0 adds exactly 1.
- MEM_HANDSHAKE=0: memory states always take exactly one cycle.
- Invariants: MemRead and MemWrite are never both 1. PCWrite, PCWriteCond and PCWriteCondNe are mutually exclusive.

Test Plan:
- rst=1 for 2 cycles, then low with mem_ready=1 -> all outputs 0 during reset. FETCH on the first cycle after release, with MemRead=1, IRWrite=1 and PCWrite=1.
- op_code=100011, mem_ready=1 -> state_o sequence 0,1,2,3,4. RegWrite=1 and MemtoReg=1 in cycle 5. instr_done pulses once.
- op_code=101011, with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held high for 4 cycles. instr_done and return to FETCH on the cycle mem_ready=1. No RegWrite.
- op_code=000101 -> PCWriteCondNe=1 and PCWriteCond=0 in the BNE state. Repeat with 000100: PCWriteCond=1 and PCWriteCondNe=0.
- op_code=001100 -> ALUOp=11 in IEXEC, RegWrite=1 with RegDst=0 in IWB, 4 cycles total. Repeat with 001000: ALUOp=00 in IEXEC.
- op_code=111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, no writes. A separate run asserts rst in MEMRD -> FETCH next cycle, RegWrite never asserted.
